// File: rtl/poli_ctrl_bank.sv
// Register bank and control FSM for the polarisation-gate test rig: drives a CRC engine
// through a start/timeout handshake and exposes NCH gate test channels.
module poli_ctrl_bank #(
  parameter int NCH    = 4,
  parameter int ADDR_W = 5,
  parameter int TO_W   = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] register_select,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              crc_start,
  output logic              crc_reset,
  output logic [31:0]       crc_orient,
  output logic [31:0]       crc_data_in,
  input  logic              crc_ready,
  input  logic [31:0]       crc_data_out,
  output logic [NCH-1:0]    ch_orient,
  output logic [NCH-1:0]    ch_a,
  output logic [NCH-1:0]    ch_b,
  input  logic [NCH-1:0]    ch_out,
  output logic              irq
);

  localparam logic [31:0] IDX_ID      = 32'd0;
  localparam logic [31:0] IDX_CTRL    = 32'd1;
  localparam logic [31:0] IDX_CONFIG  = 32'd2;
  localparam logic [31:0] IDX_STATUS  = 32'd3;
  localparam logic [31:0] IDX_INPUT   = 32'd4;
  localparam logic [31:0] IDX_RESULT  = 32'd5;
  localparam logic [31:0] IDX_IRQ_EN  = 32'd6;
  localparam logic [31:0] IDX_TIMEOUT = 32'd7;
  localparam int          CH_BASE     = 8;
  localparam logic [31:0] ID_VALUE    = 32'h504F_4C00 | 32'(NCH);
  localparam logic [31:0] UNMAPPED    = 32'hBAD1_BAD1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] counter;
  logic [TO_W-1:0] timeout_reg;
  logic [1:0]      irq_en;
  logic [31:0]     crc_result;
  logic            done, tmo;

  logic [31:0] sel;
  logic        wr_ctrl, wr_status;
  logic        start_req, reset_req, accept, tmo_hit, done_set, tmo_set;

  assign sel       = 32'(register_select);
  assign wr_ctrl   = write_enable && (sel == IDX_CTRL);
  assign wr_status = write_enable && (sel == IDX_STATUS);
  assign start_req = wr_ctrl && write_data[0] && !write_data[1] && (state == IDLE);
  assign reset_req = wr_ctrl && write_data[1];
  // The pulse cycle is the first BUSY cycle, so a ready seen alongside crc_start is stale.
  assign accept    = (state == BUSY) && !crc_start && crc_ready;
  assign tmo_hit   = (state == BUSY) && !crc_ready && (timeout_reg != '0) && (counter == timeout_reg);
  assign done_set  = accept && !reset_req;
  assign tmo_set   = tmo_hit && !reset_req;

  // NOTE: always_comb assigns every output a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_req) state_nxt = BUSY;
      BUSY:    if (accept || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (reset_req) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      counter     <= '0;
      crc_start   <= 1'b0;
      crc_reset   <= 1'b0;
      crc_orient  <= '0;
      crc_data_in <= '0;
      crc_result  <= '0;
      done        <= 1'b0;
      tmo         <= 1'b0;
      irq_en      <= '0;
      timeout_reg <= '0;
    end else begin
      state     <= state_nxt;
      crc_start <= start_req;
      // Back-to-back reset writes must not stretch the pulse.
      crc_reset <= reset_req && !crc_reset;

      if (start_req)            counter <= '0;
      else if (state == BUSY)   counter <= counter + 1'b1;

      if (done_set) crc_result <= crc_data_out;

      if (done_set)                         done <= 1'b1;
      else if (wr_status && write_data[1])  done <= 1'b0;
      if (tmo_set)                          tmo  <= 1'b1;
      else if (wr_status && write_data[2])  tmo  <= 1'b0;

      if (write_enable) begin
        case (sel)
          IDX_CONFIG:  crc_orient  <= write_data;
          IDX_INPUT:   crc_data_in <= write_data;
          IDX_IRQ_EN:  irq_en      <= write_data[1:0];
          IDX_TIMEOUT: timeout_reg <= write_data[TO_W-1:0];
          default:     ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ch_orient <= '0;
      ch_a      <= '0;
      ch_b      <= '0;
    end else if (write_enable) begin
      for (int k = 0; k < NCH; k++) begin
        if (sel == 32'(CH_BASE + 2 * k)) begin
          ch_orient[k] <= write_data[0];
          ch_a[k]      <= write_data[1];
          ch_b[k]      <= write_data[2];
        end
      end
    end
  end

  always_comb begin
    read_data = UNMAPPED;
    case (sel)
      IDX_ID:      read_data = ID_VALUE;
      IDX_CTRL:    read_data = '0;
      IDX_CONFIG:  read_data = crc_orient;
      IDX_STATUS:  read_data = {28'd0, (state == BUSY), tmo, done, crc_ready};
      IDX_INPUT:   read_data = crc_data_in;
      IDX_RESULT:  read_data = crc_result;
      IDX_IRQ_EN:  read_data = {30'd0, irq_en};
      IDX_TIMEOUT: read_data = 32'(timeout_reg);
      default: begin
        for (int k = 0; k < NCH; k++) begin
          if (sel == 32'(CH_BASE + 2 * k))     read_data = {29'd0, ch_b[k], ch_a[k], ch_orient[k]};
          if (sel == 32'(CH_BASE + 2 * k + 1)) read_data = {31'd0, ch_out[k]};
        end
      end
    endcase
  end

  assign irq = (done & irq_en[0]) | (tmo & irq_en[1]);

endmodule
